// File: rtl/pp3_sync_fifo_pkg.sv
// pp3_sync_fifo_pkg
// Shared types and helpers for the PP3 synchronous FIFO slice.
//   addr_width() : pointer width for a power-of-two depth
//   fifo_op_e    : per-cycle accepted-operation encoding {write, read}
package pp3_sync_fifo_pkg;

    // Pointer width for a power-of-two depth (depth >= 2).
    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Which requests were accepted this cycle, encoded as {write, read}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/pp3_sync_fifo_ptr.sv
// pp3_sync_fifo_ptr
// AW-bit wrapping pointer built from a single sync-reset, clock-enabled flop bank.
// Ports:
//   CLK : rising-edge clock
//   RST : synchronous active-high reset, clears Q
//   INC : advance by one, wrapping from 2**AW-1 to 0 by natural overflow
//   Q   : current pointer value
module pp3_sync_fifo_ptr #(
    parameter int AW = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          INC,
    output logic [AW-1:0] Q
);

    logic [AW-1:0] q_r;

    // Pointer register: reset folded into D, INC acts as clock enable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_r <= {AW{1'b0}};
        end else if (INC) begin
            q_r <= q_r + AW'(1);
        end
    end

    assign Q = q_r;

endmodule

// File: rtl/pp3_sync_fifo.sv
// pp3_sync_fifo
// Small synchronous FIFO made only of sync-reset / clock-enabled D flops, so the
// whole datapath (storage, pointers, occupancy, sticky flags) stays sync-only.
// Ports:
//   CLK   : rising-edge clock
//   RST   : synchronous active-high reset (contents discarded, mem untouched)
//   WR_EN : write request, accepted when not FULL
//   DIN   : write data
//   RD_EN : read request, accepted when not EMPTY
//   DOUT  : registered read data, holds when no read is accepted
//   FULL  : COUNT == DEPTH
//   EMPTY : COUNT == 0
//   COUNT : current occupancy
//   OVF   : sticky, write requested while full
//   UDF   : sticky, read requested while empty
module pp3_sync_fifo
    import pp3_sync_fifo_pkg::*;
#(
    parameter int   WIDTH = 8,
    parameter int   DEPTH = 4,
    parameter logic INIT  = 1'b0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       WR_EN,
    input  logic [WIDTH-1:0]           DIN,
    input  logic                       RD_EN,
    output logic [WIDTH-1:0]           DOUT,
    output logic                       FULL,
    output logic                       EMPTY,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       OVF,
    output logic                       UDF
);

    localparam int AW = addr_width(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] dout_r;
    logic [CW-1:0]    count_r;
    logic             ovf_r;
    logic             udf_r;

    logic [AW-1:0]    wptr_s;
    logic [AW-1:0]    rptr_s;
    logic             full_s;
    logic             empty_s;
    logic             wa_s;
    logic             ra_s;
    fifo_op_e         op_s;

    // Flags decode purely from the occupancy register.
    assign full_s  = (count_r == CW'(DEPTH));
    assign empty_s = (count_r == {CW{1'b0}});

    // Accept decisions use the flags from before the edge; encode the result.
    always_comb begin
        wa_s = WR_EN & ~full_s;
        ra_s = RD_EN & ~empty_s;
        case ({wa_s, ra_s})
            2'b01:   op_s = OP_READ;
            2'b10:   op_s = OP_WRITE;
            2'b11:   op_s = OP_BOTH;
            default: op_s = OP_IDLE;
        endcase
    end

    pp3_sync_fifo_ptr #(.AW(AW)) u_wptr (
        .CLK (CLK),
        .RST (RST),
        .INC (wa_s),
        .Q   (wptr_s)
    );

    pp3_sync_fifo_ptr #(.AW(AW)) u_rptr (
        .CLK (CLK),
        .RST (RST),
        .INC (ra_s),
        .Q   (rptr_s)
    );

    // Storage: plain enabled flops, never reset; RST blocks the write so mem is untouched.
    always_ff @(posedge CLK) begin
        if (!RST && wa_s) begin
            mem_r[wptr_s] <= DIN;
        end
    end

    // Occupancy: +1 on write only, -1 on read only, hold on both or neither.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_r <= {CW{1'b0}};
        end else begin
            case (op_s)
                OP_WRITE: count_r <= count_r + CW'(1);
                OP_READ:  count_r <= count_r - CW'(1);
                default:  count_r <= count_r;
            endcase
        end
    end

    // Registered read data; loads only on an accepted read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dout_r <= {WIDTH{INIT}};
        end else if (ra_s) begin
            dout_r <= mem_r[rptr_s];
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r | (WR_EN & full_s);
            udf_r <= udf_r | (RD_EN & empty_s);
        end
    end

    assign DOUT  = dout_r;
    assign FULL  = full_s;
    assign EMPTY = empty_s;
    assign COUNT = count_r;
    assign OVF   = ovf_r;
    assign UDF   = udf_r;

endmodule

// File: tb/tb_pp3_sync_fifo.sv
// tb_pp3_sync_fifo
// Scoreboard bench: stimulus drives on the falling edge and pushes the expected
// post-edge response; the monitor pops and compares just after each rising edge.
// A second instance with INIT=1 shares the stimulus to cover the reset pattern.
module tb_pp3_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] dout0, dout1;
    logic       full0, empty0, ovf0, udf0;
    logic       full1, empty1, ovf1, udf1;
    logic [2:0] count0, count1;

    always #5 clk = ~clk;

    pp3_sync_fifo #(.WIDTH(8), .DEPTH(4), .INIT(1'b0)) dut0 (
        .CLK(clk), .RST(rst), .WR_EN(wr_en), .DIN(din), .RD_EN(rd_en),
        .DOUT(dout0), .FULL(full0), .EMPTY(empty0), .COUNT(count0),
        .OVF(ovf0), .UDF(udf0)
    );

    pp3_sync_fifo #(.WIDTH(8), .DEPTH(4), .INIT(1'b1)) dut1 (
        .CLK(clk), .RST(rst), .WR_EN(wr_en), .DIN(din), .RD_EN(rd_en),
        .DOUT(dout1), .FULL(full1), .EMPTY(empty1), .COUNT(count1),
        .OVF(ovf1), .UDF(udf1)
    );

    typedef struct packed {
        logic [7:0] dout;
        logic [7:0] dout1;
        logic [2:0] count;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       udf;
    } exp_t;

    exp_t       scb_q[$];
    logic [7:0] mq[$];
    int         m_count = 0;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic [7:0] m_dout = 8'h00;
    logic [7:0] m_dout1 = 8'hFF;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle: drive inputs, advance the reference model, queue the response.
    task automatic step(input logic r, input logic w, input logic [7:0] d, input logic rd);
        logic wa, ra;
        exp_t e;
        @(negedge clk);
        rst = r; wr_en = w; din = d; rd_en = rd;
        if (r) begin
            m_count = 0; m_ovf = 1'b0; m_udf = 1'b0;
            m_dout = 8'h00; m_dout1 = 8'hFF;
            mq.delete();
        end else begin
            wa = w && (m_count < 4);
            ra = rd && (m_count > 0);
            if (w && m_count == 4) m_ovf = 1'b1;
            if (rd && m_count == 0) m_udf = 1'b1;
            if (ra) begin
                m_dout  = mq.pop_front();
                m_dout1 = m_dout;
            end
            if (wa) mq.push_back(d);
            if (wa && !ra) m_count++;
            if (ra && !wa) m_count--;
        end
        e.dout  = m_dout;
        e.dout1 = m_dout1;
        e.count = 3'(m_count);
        e.full  = (m_count == 4);
        e.empty = (m_count == 0);
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        scb_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (scb_q.size() > 0) begin
                e = scb_q.pop_front();
                chk("dout",  dout0,  e.dout);
                chk("dout_init1", dout1, e.dout1);
                chk("count", {5'd0, count0}, {5'd0, e.count});
                chk("count_init1", {5'd0, count1}, {5'd0, e.count});
                chk("full",  {7'd0, full0},  {7'd0, e.full});
                chk("empty", {7'd0, empty0}, {7'd0, e.empty});
                chk("ovf",   {7'd0, ovf0},   {7'd0, e.ovf});
                chk("udf",   {7'd0, udf0},   {7'd0, e.udf});
            end
        end
    end

    initial begin
        // Reset: DOUT = 00 (INIT=0) / FF (INIT=1), EMPTY, COUNT=0, no sticky flags.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Read while empty: UDF set, DOUT holds 00.
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Fill A1..A4, overflow with A5, drain four, then one extra read.
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Two entries, then six simultaneous read/write cycles wrapping the pointers.
        step(1'b0, 1'b1, 8'hB0, 1'b0);
        step(1'b0, 1'b1, 8'hB1, 1'b0);
        for (int i = 2; i < 8; i++) step(1'b0, 1'b1, 8'hB0 + 8'(i), 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Full plus simultaneous read/write: oldest read, CC dropped, OVF set.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0);
        step(1'b0, 1'b1, 8'hCC, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Reset mid-stream together with a write: contents discarded.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hD0 + 8'(i), 1'b0);
        step(1'b1, 1'b1, 8'hDF, 1'b0);
        step(1'b0, 1'b1, 8'hE0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        @(negedge clk);
        @(negedge clk);
        chk("scb_drain", 8'(scb_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
